// File: rtl/ei_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : regs_if / regs_int_if
//  Description : Host read/write bus and top-level link bundles for
//                ei_register_file.
//  Revision    : 1.0 - initial release
// ============================================================================

interface regs_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  write_en;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output write_en,
        output read_en,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_en,
        input  read_en,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

interface regs_int_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64
);
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regi;
    logic [DATA_DEPTH-1:0]                 mode_mask;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rego;

    modport master (
        output regi,
        output mode_mask,
        input  rego
    );

    modport slave (
        input  regi,
        input  mode_mask,
        output rego
    );
endinterface

`default_nettype wire

// File: rtl/ei_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : ei_register_file
//  Description : EI configuration register file with per-register reset
//                values, read-only mask and live export of all registers.
//                Optional write-reject pulse enabled by REGFILE_WR_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module ei_register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regs_if.slave       if_regs_inst,
    regs_int_if.slave   if_top_link
`ifdef REGFILE_WR_ERR_EN
    ,
    output logic        wr_err
`endif
);

    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] r_regs;
    logic [DATA_WIDTH-1:0]                 r_read_data;
    logic                                  w_in_range;
    logic                                  w_read_only;
    logic                                  w_write_ok;

    // Out-of-range addresses only exist when the depth is not a power of two.
    generate
        if (DATA_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_partial_range
            assign w_in_range = ({1'b0, if_regs_inst.addr} < (ADDR_WIDTH+1)'(DATA_DEPTH));
        end
    endgenerate

    assign w_read_only = w_in_range ? if_top_link.mode_mask[if_regs_inst.addr] : 1'b0;
    assign w_write_ok  = if_regs_inst.write_en & w_in_range & ~w_read_only;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= if_top_link.regi;
        end else if (w_write_ok) begin
            r_regs[if_regs_inst.addr] <= if_regs_inst.write_data;
        end
    end

    // Reads sample the array before this edge's write lands: read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (if_regs_inst.read_en) begin
            r_read_data <= w_in_range ? r_regs[if_regs_inst.addr] : '0;
        end
    end

    assign if_regs_inst.read_data = r_read_data;
    assign if_top_link.rego       = r_regs;

`ifdef REGFILE_WR_ERR_EN
    logic r_wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= if_regs_inst.write_en & (~w_in_range | w_read_only);
        end
    end

    assign wr_err = r_wr_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ei_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ei_register_file
//  Description : Directed scoreboard bench for ei_register_file.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_ei_register_file;

    localparam int c_dw        = 8;
    localparam int c_depth     = 64;
    localparam int c_aw        = 6;
    localparam int c_eir_test  = 62;
    localparam int c_eir_baud  = 20;
    localparam int c_eir_adv   = 10;
    localparam int c_eir_ack   = 13;
    localparam int c_eir_name  = 16;

    logic clk;
    logic rst;
`ifdef REGFILE_WR_ERR_EN
    logic wr_err;
    logic exp_err;
`endif

    regs_if     #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw))  u_regs_if ();
    regs_int_if #(.DATA_WIDTH(c_dw), .DATA_DEPTH(c_depth)) u_int_if ();

    logic [c_depth-1:0][c_dw-1:0] regi_v;
    logic [c_depth-1:0]           mask_v;
    logic [c_depth-1:0][c_dw-1:0] model;
    logic [c_dw-1:0]              sb_q[$];
    logic [c_dw-1:0]              exp_rd;
    int                           n_cmp;
    int                           n_fail;

    assign u_int_if.regi      = regi_v;
    assign u_int_if.mode_mask = mask_v;

    ei_register_file #(
        .DATA_WIDTH (c_dw),
        .DATA_DEPTH (c_depth),
        .ADDR_WIDTH (c_aw)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .if_regs_inst (u_regs_if),
        .if_top_link  (u_int_if)
`ifdef REGFILE_WR_ERR_EN
        ,
        .wr_err       (wr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of host traffic; the model applies read-before-write ordering.
    task automatic cycle(input logic we, input logic re, input logic [c_aw-1:0] a,
                         input logic [c_dw-1:0] wd);
        u_regs_if.write_en   = we;
        u_regs_if.read_en    = re;
        u_regs_if.addr       = a;
        u_regs_if.write_data = wd;
        if (re) sb_q.push_back(model[a]);
`ifdef REGFILE_WR_ERR_EN
        exp_err = we && mask_v[a];
`endif
        if (we && !mask_v[a]) model[a] = wd;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
        check("read_data", {504'd0, u_regs_if.read_data}, {504'd0, exp_rd});
        check("rego", u_int_if.rego, model);
`ifdef REGFILE_WR_ERR_EN
        check("wr_err", {511'd0, wr_err}, {511'd0, exp_err});
`endif
    endtask

    task automatic read_expect(input string tag, input logic [c_aw-1:0] a, input logic [c_dw-1:0] v);
        cycle(1'b0, 1'b1, a, 8'h00);
        check(tag, {504'd0, u_regs_if.read_data}, {504'd0, v});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        u_regs_if.write_en   = 1'b0;
        u_regs_if.read_en    = 1'b0;
        u_regs_if.addr       = '0;
        u_regs_if.write_data = '0;
        for (int i = 0; i < c_depth; i++) regi_v[i] = 8'(i) ^ 8'hC0;
        regi_v[c_eir_test]   = 8'hAA;
        regi_v[c_eir_baud]   = 8'h30;
        regi_v[c_eir_adv+0]  = 8'h40;
        regi_v[c_eir_adv+1]  = 8'h4B;
        regi_v[c_eir_adv+2]  = 8'h4C;
        regi_v[c_eir_ack+0]  = 8'h10;
        regi_v[c_eir_ack+1]  = 8'h27;
        regi_v[c_eir_ack+2]  = 8'h00;
        regi_v[c_eir_name+0] = "O";
        regi_v[c_eir_name+1] = "C";
        regi_v[c_eir_name+2] = "V";
        regi_v[c_eir_name+3] = "1";
        mask_v = '0;
        mask_v[c_eir_test] = 1'b1;
        mask_v[c_eir_baud] = 1'b1;

        // Reset load
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_data", {504'd0, u_regs_if.read_data}, 512'd0);
        check("rst_rego", u_int_if.rego, regi_v);
`ifdef REGFILE_WR_ERR_EN
        check("rst_wr_err", {511'd0, wr_err}, 512'd0);
        exp_err = 1'b0;
`endif
        rst    = 1'b0;
        model  = regi_v;
        exp_rd = '0;
        read_expect("rd_test",  6'(c_eir_test),   8'hAA);
        read_expect("rd_baud",  6'(c_eir_baud),   8'h30);
        read_expect("rd_adv0",  6'(c_eir_adv),    8'h40);
        read_expect("rd_adv2",  6'(c_eir_adv+2),  8'h4C);
        read_expect("rd_ack1",  6'(c_eir_ack+1),  8'h27);
        read_expect("rd_name0", 6'(c_eir_name),   8'h4F);
        read_expect("rd_name3", 6'(c_eir_name+3), 8'h31);

        // Write sweep and full read-back
        for (int i = 0; i < c_depth; i++) cycle(1'b1, 1'b0, 6'(i), 8'(i));
        for (int i = 0; i < c_depth; i++) begin
            read_expect("sweep", 6'(i),
                        (i == c_eir_test) ? 8'hAA : (i == c_eir_baud) ? 8'h30 : 8'(i));
        end

        // Read latency and hold
        read_expect("lat_rd5", 6'd5, 8'd5);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 6'(33 + i), 8'hFF);
            check("hold_rd5", {504'd0, u_regs_if.read_data}, 512'd5);
        end

        // Same-address read and write
        cycle(1'b1, 1'b1, 6'd7, 8'h55);
        check("rbw_old", {504'd0, u_regs_if.read_data}, 512'd7);
        read_expect("rbw_new", 6'd7, 8'h55);

        // Rejected write to a read-only register
        cycle(1'b1, 1'b0, 6'(c_eir_test), 8'h11);
`ifdef REGFILE_WR_ERR_EN
        check("err_pulse", {511'd0, wr_err}, 512'd1);
`endif
        cycle(1'b0, 1'b0, 6'd0, 8'h00);
        read_expect("ro_keep", 6'(c_eir_test), 8'hAA);
        cycle(1'b1, 1'b0, 6'd9, 8'h99);
`ifdef REGFILE_WR_ERR_EN
        check("err_none", {511'd0, wr_err}, 512'd0);
`endif
        read_expect("wr9", 6'd9, 8'h99);

        // Run-time mask change
        mask_v[30] = 1'b1;
        cycle(1'b1, 1'b0, 6'd30, 8'h77);
        read_expect("mask_rt", 6'd30, 8'd30);
        mask_v[30] = 1'b0;

        // Reset in the middle of a write burst
        cycle(1'b1, 1'b0, 6'd40, 8'hE0);
        cycle(1'b1, 1'b0, 6'd41, 8'hE1);
        cycle(1'b1, 1'b0, 6'd42, 8'hE2);
        u_regs_if.write_en   = 1'b1;
        u_regs_if.addr       = 6'd43;
        u_regs_if.write_data = 8'hE3;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rego", u_int_if.rego, regi_v);
        check("midrst_read_data", {504'd0, u_regs_if.read_data}, 512'd0);
        @(posedge clk);
        #1;
        u_regs_if.write_en = 1'b0;
        rst    = 1'b0;
        model  = regi_v;
        exp_rd = '0;
        sb_q.delete();
`ifdef REGFILE_WR_ERR_EN
        exp_err = 1'b0;
`endif
        read_expect("midrst_40", 6'd40, 8'hE8);
        read_expect("midrst_43", 6'd43, 8'hEB);
        cycle(1'b0, 1'b0, 6'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ei_register_file.md
# ei_register_file

Configuration register file for the EI memory subsystem: `DATA_DEPTH` registers of `DATA_WIDTH` bits each. The host side reads and writes through the `regs_if` slave port. The top-level link, `regs_int_if` (slave), supplies per-register reset values and a read-only mask, and receives the live register contents for the rest of the design (timers, device name/PIN, baud rate, etc.).

## Interface
- `DATA_WIDTH`, default 8: bits per register.
- `DATA_DEPTH`, default 64: number of registers.
- `ADDR_WIDTH`, default `$clog2(DATA_DEPTH)`: address width (derived).

Ports (the `if_regs_inst` and `if_top_link` interface bundles are shown flattened):
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `write_en` in 1: host write strobe (`regs_if`).
- `read_en` in 1: host read strobe (`regs_if`).
- `addr` in `ADDR_WIDTH`: register address (`regs_if`).
- `write_data` in `DATA_WIDTH`: write data (`regs_if`).
- `read_data` out `DATA_WIDTH`: registered read data (`regs_if`).
- `regi` in `DATA_DEPTH`×`DATA_WIDTH`: per-register reset value (`regs_int_if`).
- `mode_mask` in `DATA_DEPTH`: 1 = register is read-only (`regs_int_if`).
- `rego` out `DATA_DEPTH`×`DATA_WIDTH`: current contents of every register (`regs_int_if`).
- `wr_err` out 1: write-rejected pulse. Present only with `REGFILE_WR_ERR_EN`.

## Operation
- **Reset:** while `rst` is high, `reg[i]` = `regi[i]` for all i, `read_data` = 0 and `wr_err` = 0. `regi` must be stable while reset is asserted; after reset release it is ignored.
- **Write:** on a clock edge with `write_en`=1, `addr` < `DATA_DEPTH` and `mode_mask[addr]`=0, `reg[addr]` ← `write_data`. Otherwise the registers are unchanged.
- **Read-only registers** (`mode_mask`=1) keep their reset value permanently. Host writes to them are silently dropped, except that they flag `wr_err` when that option is enabled.
- **Read:** on a clock edge with `read_en`=1, `read_data` ← `reg[addr]`. If `addr` ≥ `DATA_DEPTH`, `read_data` ← 0. When `read_en`=0, `read_data` holds its last value.
- **Simultaneous `read_en` and `write_en` to the same address:** `read_data` returns the old (pre-write) value, i.e. read-before-write.
- **Export:** `rego` is driven combinationally from the register array and reflects a write the cycle after the write edge.
- `mode_mask` is sampled every cycle, so changing it at run time takes effect immediately.
- `addr` has no wrap-around. Out-of-range addresses are only possible when `DATA_DEPTH` is not a power of two and are handled as above.

## Timing
- Write latency: 1 edge. The data is visible on `rego` and on a subsequent read after that edge.
- Read latency: 1 cycle. With `addr` and `read_en` presented before edge N, `read_data` is valid after edge N.
- Back-to-back reads and writes are supported every cycle. There is no handshake or stall.
- Reset asserted mid-operation: the array is immediately restored to `regi`, and an in-flight write is lost.
- `wr_err` is registered and lasts one cycle, asserted on the edge after the rejected write.

## Configuration
- **`REGFILE_WR_ERR_EN` defined:** the `wr_err` output exists. It pulses high for 1 cycle for each `write_en` edge that targets a read-only register or an address ≥ `DATA_DEPTH`.
- **Without `REGFILE_WR_ERR_EN`:** there is no `wr_err` port, and rejected writes are fully silent. All other behaviour is identical in both builds.

## Test plan
- **Reset load:** set `regi[EIR_TEST]`=0xAA, `regi[EIR_BAUD_RATE]`=0x30, the 24-bit timers (e.g. ADV=5_000_000, ACK=10_000) and the name "OCV1", then pulse `rst`. Required: `rego` and reads return exactly those values, and `read_data`=0 during reset.
- **Write sweep:** write `reg[i]`=i for i=0..63 with `mode_mask` clear except EIR_TEST and EIR_BAUD_RATE, then read all 64 addresses. Required: `read_data`=i everywhere except EIR_TEST=0xAA and EIR_BAUD_RATE=0x30.
- **Read latency/hold:** read addr 5 (value 5), then deassert `read_en` and change `addr`. Required: `read_data` becomes 5 one cycle after the request and stays 5.
- **Same-address read and write:** `reg[7]`=7; assert `read_en` and `write_en` on addr 7 with `write_data`=0x55. Required: `read_data`=7 that cycle, and the next read returns 0x55.
- **Reset mid-write:** assert `rst` during a write burst. Required: all registers immediately return to `regi`, and the burst's writes are lost.
- **`REGFILE_WR_ERR_EN`:** write 0x11 to EIR_TEST. Required: a 1-cycle `wr_err` pulse and EIR_TEST still reads 0xAA. A write to a writable address produces no pulse.
